// File: rtl/unified_buffer_arbiter_pkg.sv
// Shared constants and types for the unified buffer arbiter slice.
//   UB_ADDR_W / UB_DATA_W : default buffer address / word widths
//   arb_state_t           : arbiter FSM states (ARB, LOCK)
//   requester_t           : identifies the requester selected for the port
package tpu_package;

  localparam int unsigned UB_ADDR_W = 12;
  localparam int unsigned UB_DATA_W = 256;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_RD   = 2'd0,
    REQ_WB   = 2'd1,
    REQ_HOST = 2'd2
  } requester_t;

endpackage

// File: rtl/unified_buffer_arbiter_if.sv
// Request/grant and buffer-port bundle of the unified buffer arbiter.
// Signal suffixes (_i/_o) are from the arbiter's point of view.
//   slave  : arbiter side (reads requests and buffer read data, drives grants and port)
//   master : requester/buffer side (the mirror of slave)
interface unified_buffer_arbiter_if #(
  parameter int unsigned UB_ADDR_W = tpu_package::UB_ADDR_W,
  parameter int unsigned UB_DATA_W = tpu_package::UB_DATA_W
);

  logic                 rd_req_i;
  logic [UB_ADDR_W-1:0] rd_addr_i;
  logic                 rd_lock_i;
  logic                 rd_gnt_o;
  logic [UB_DATA_W-1:0] rd_data_o;
  logic                 rd_valid_o;

  logic                 wb_req_i;
  logic [UB_ADDR_W-1:0] wb_addr_i;
  logic [UB_DATA_W-1:0] wb_data_i;
  logic                 wb_gnt_o;

  logic                 host_req_i;
  logic [UB_ADDR_W-1:0] host_addr_i;
  logic [UB_DATA_W-1:0] host_data_i;
  logic                 host_gnt_o;

  logic                 ub_en_o;
  logic                 ub_we_o;
  logic [UB_ADDR_W-1:0] ub_addr_o;
  logic [UB_DATA_W-1:0] ub_wdata_o;
  logic [UB_DATA_W-1:0] ub_rdata_i;

  modport slave (
    input  rd_req_i, rd_addr_i, rd_lock_i,
    input  wb_req_i, wb_addr_i, wb_data_i,
    input  host_req_i, host_addr_i, host_data_i,
    input  ub_rdata_i,
    output rd_gnt_o, rd_data_o, rd_valid_o, wb_gnt_o, host_gnt_o,
    output ub_en_o, ub_we_o, ub_addr_o, ub_wdata_o
  );

  modport master (
    output rd_req_i, rd_addr_i, rd_lock_i,
    output wb_req_i, wb_addr_i, wb_data_i,
    output host_req_i, host_addr_i, host_data_i,
    output ub_rdata_i,
    input  rd_gnt_o, rd_data_o, rd_valid_o, wb_gnt_o, host_gnt_o,
    input  ub_en_o, ub_we_o, ub_addr_o, ub_wdata_o
  );

endinterface

// File: rtl/unified_buffer_arbiter_ub_starve_counter.sv
// Saturating wait counter for one write requester.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i, gnt_i : requester's request and grant
//   starved_o    : counter has reached STARVE_LIMIT
module ub_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic starved_o
);

  localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!req_i || gnt_i) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved_o = (count_q == LIMIT);

endmodule

// File: rtl/unified_buffer_arbiter.sv
// Single-port unified buffer arbiter: array read (rd), accumulator writeback
// (wb) and host load (host) share one synchronous-read buffer port.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : request/grant signals of the three requesters plus the
//                  buffer port (en/we/addr/wdata out, rdata in)
// Priority rd > wb > host, except a write requester that has waited
// STARVE_LIMIT cycles beats rd. A granted read with rd_lock_i held keeps the
// port for a burst (LOCK) until lock or request drops.
module unified_buffer_arbiter
  import tpu_package::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned UB_DATA_W    = tpu_package::UB_DATA_W,
  parameter int unsigned UB_ADDR_W    = tpu_package::UB_ADDR_W
) (
  input logic                    clk_i,
  input logic                    rst_i,
  unified_buffer_arbiter_if.slave bus
);

  arb_state_t           state_q, state_d;
  requester_t           winner;
  logic                 gnt_any;
  logic                 lock_hold;
  logic                 wb_starved, host_starved;
  logic                 rd_gnt, wb_gnt, host_gnt;
  logic                 rd_valid_q, rd_valid_d;
  logic [UB_ADDR_W-1:0] addr_mux;
  logic [UB_DATA_W-1:0] wdata_mux;

  ub_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_wb_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (bus.wb_req_i),
    .gnt_i    (wb_gnt),
    .starved_o(wb_starved)
  );

  ub_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_host_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (bus.host_req_i),
    .gnt_i    (host_gnt),
    .starved_o(host_starved)
  );

  // A LOCK that is about to be released falls through to the ARB rules in
  // the same cycle, so only the "still locked" case is special-cased.
  always_comb begin
    winner    = REQ_RD;
    gnt_any   = 1'b0;
    lock_hold = (state_q == ST_LOCK) && bus.rd_lock_i && bus.rd_req_i;
    if (rst_i) begin
      gnt_any = 1'b0;
    end else if (lock_hold) begin
      winner  = REQ_RD;
      gnt_any = 1'b1;
    end else if (wb_starved && bus.wb_req_i) begin
      winner  = REQ_WB;
      gnt_any = 1'b1;
    end else if (host_starved && bus.host_req_i) begin
      winner  = REQ_HOST;
      gnt_any = 1'b1;
    end else if (bus.rd_req_i) begin
      winner  = REQ_RD;
      gnt_any = 1'b1;
    end else if (bus.wb_req_i) begin
      winner  = REQ_WB;
      gnt_any = 1'b1;
    end else if (bus.host_req_i) begin
      winner  = REQ_HOST;
      gnt_any = 1'b1;
    end
  end

  assign rd_gnt   = gnt_any && (winner == REQ_RD);
  assign wb_gnt   = gnt_any && (winner == REQ_WB);
  assign host_gnt = gnt_any && (winner == REQ_HOST);

  // Both ARB->LOCK and LOCK->LOCK reduce to "rd granted with lock held";
  // every other case (including release) lands in ARB.
  always_comb begin
    state_d    = (rd_gnt && bus.rd_lock_i) ? ST_LOCK : ST_ARB;
    rd_valid_d = rd_gnt;
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt_any) begin
      case (winner)
        REQ_RD:   addr_mux = bus.rd_addr_i;
        REQ_WB: begin
          addr_mux  = bus.wb_addr_i;
          wdata_mux = bus.wb_data_i;
        end
        REQ_HOST: begin
          addr_mux  = bus.host_addr_i;
          wdata_mux = bus.host_data_i;
        end
        default: begin
          addr_mux  = '0;
          wdata_mux = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ARB;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_gnt_o   = rd_gnt;
  assign bus.wb_gnt_o   = wb_gnt;
  assign bus.host_gnt_o = host_gnt;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = bus.ub_rdata_i;
  assign bus.ub_en_o    = rd_gnt | wb_gnt | host_gnt;
  assign bus.ub_we_o    = wb_gnt | host_gnt;
  assign bus.ub_addr_o  = addr_mux;
  assign bus.ub_wdata_o = wdata_mux;

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
module tb_unified_buffer_arbiter;
  import tpu_package::*;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 256;
  localparam int unsigned LIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_buffer_arbiter_if #(.UB_ADDR_W(AW), .UB_DATA_W(DW)) bus ();

  unified_buffer_arbiter #(
    .STARVE_LIMIT(LIM),
    .UB_DATA_W   (DW),
    .UB_ADDR_W   (AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_d;

  localparam logic [DW-1:0] D_WB   = {8{32'hC0DE_0020}};
  localparam logic [DW-1:0] D_HOST = {8{32'hBEEF_0030}};

  // Buffer model: read word content is a fixed function of the address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    pat = {16{4'hA, a}};
  endfunction

  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.ub_en_o && !bus.ub_we_o) rdata_q <= pat(bus.ub_addr_o);
  end
  assign bus.ub_rdata_i = rdata_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.rd_req_i    = 1'b0;
    bus.rd_lock_i   = 1'b0;
    bus.rd_addr_i   = '0;
    bus.wb_req_i    = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_data_i   = '0;
    bus.host_req_i  = 1'b0;
    bus.host_addr_i = '0;
    bus.host_data_i = '0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b1;
    bus.rd_req_i = 1'b1; bus.wb_req_i = 1'b1; bus.host_req_i = 1'b1;
    @(negedge clk);
    total++; if (bus.rd_gnt_o !== 1'b0)   begin bad++; $display("FAIL rst_rd_gnt: got %0h want 0", bus.rd_gnt_o); end
    total++; if (bus.wb_gnt_o !== 1'b0)   begin bad++; $display("FAIL rst_wb_gnt: got %0h want 0", bus.wb_gnt_o); end
    total++; if (bus.host_gnt_o !== 1'b0) begin bad++; $display("FAIL rst_host_gnt: got %0h want 0", bus.host_gnt_o); end
    total++; if (bus.ub_en_o !== 1'b0)    begin bad++; $display("FAIL rst_ub_en: got %0h want 0", bus.ub_en_o); end
    total++; if (bus.ub_we_o !== 1'b0)    begin bad++; $display("FAIL rst_ub_we: got %0h want 0", bus.ub_we_o); end
    total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %0h want 0", bus.rd_valid_o); end
    step();
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    total++; if (bus.ub_en_o !== 1'b0)    begin bad++; $display("FAIL idle_ub_en: got %0h want 0", bus.ub_en_o); end
    total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== 3'b000) begin bad++; $display("FAIL idle_gnts: got %0h want 0", {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}); end
    total++; if (dut.state_q !== ST_ARB)  begin bad++; $display("FAIL idle_state: got %0h want %0h", dut.state_q, ST_ARB); end
    step();
  endtask

  task automatic test_priority();
    clear_reqs();
    bus.rd_addr_i = 12'h010;
    bus.wb_addr_i = 12'h020; bus.wb_data_i = D_WB;
    bus.host_addr_i = 12'h030; bus.host_data_i = D_HOST;
    bus.rd_req_i = 1'b1; bus.wb_req_i = 1'b1; bus.host_req_i = 1'b1;
    @(negedge clk);
    total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== 3'b100) begin bad++; $display("FAIL pri_gnt0: got %0b want 100", {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}); end
    total++; if (bus.ub_addr_o !== 12'h010) begin bad++; $display("FAIL pri_rd_addr: got %0h want 010", bus.ub_addr_o); end
    total++; if (bus.ub_we_o !== 1'b0 || bus.ub_en_o !== 1'b1) begin bad++; $display("FAIL pri_rd_en_we: got en=%0h we=%0h want en=1 we=0", bus.ub_en_o, bus.ub_we_o); end
    total++; if (bus.ub_wdata_o !== '0) begin bad++; $display("FAIL pri_rd_wdata: got %0h want 0", bus.ub_wdata_o); end
    sb.push_back(pat(12'h010));
    step();
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    total++; if (bus.rd_valid_o !== 1'b1) begin bad++; $display("FAIL pri_rd_valid: got %0h want 1", bus.rd_valid_o); end
    if (bus.rd_valid_o) begin
      exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
      total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL pri_rd_data: got %0h want %0h", bus.rd_data_o, exp_d); end
    end
    total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== 3'b010) begin bad++; $display("FAIL pri_gnt1: got %0b want 010", {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}); end
    total++; if (bus.ub_addr_o !== 12'h020 || bus.ub_wdata_o !== D_WB || bus.ub_we_o !== 1'b1) begin bad++; $display("FAIL pri_wb_port: got addr=%0h we=%0h want addr=020 we=1", bus.ub_addr_o, bus.ub_we_o); end
    step();
    bus.wb_req_i = 1'b0;
    @(negedge clk);
    total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== 3'b001) begin bad++; $display("FAIL pri_gnt2: got %0b want 001", {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}); end
    total++; if (bus.ub_addr_o !== 12'h030 || bus.ub_wdata_o !== D_HOST || bus.ub_we_o !== 1'b1) begin bad++; $display("FAIL pri_host_port: got addr=%0h we=%0h want addr=030 we=1", bus.ub_addr_o, bus.ub_we_o); end
    total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL pri_valid_after_write: got %0h want 0", bus.rd_valid_o); end
    step();
    bus.host_req_i = 1'b0;
    @(negedge clk);
    total++; if (bus.ub_en_o !== 1'b0) begin bad++; $display("FAIL pri_idle_en: got %0h want 0", bus.ub_en_o); end
    step();
  endtask

  task automatic test_starve();
    logic exp_wb, exp_rd, prev_rd;
    clear_reqs();
    step();
    bus.rd_addr_i = 12'h050; bus.rd_req_i = 1'b1;
    bus.wb_addr_i = 12'h0A0; bus.wb_data_i = D_WB; bus.wb_req_i = 1'b1;
    prev_rd = 1'b0;
    for (int c = 0; c < 14; c++) begin
      exp_wb = (c == 8);
      exp_rd = !exp_wb;
      @(negedge clk);
      total++; if (bus.wb_gnt_o !== exp_wb) begin bad++; $display("FAIL starve_wb_gnt c=%0d: got %0h want %0h", c, bus.wb_gnt_o, exp_wb); end
      total++; if (bus.rd_gnt_o !== exp_rd) begin bad++; $display("FAIL starve_rd_gnt c=%0d: got %0h want %0h", c, bus.rd_gnt_o, exp_rd); end
      total++; if (bus.rd_valid_o !== prev_rd) begin bad++; $display("FAIL starve_rd_valid c=%0d: got %0h want %0h", c, bus.rd_valid_o, prev_rd); end
      if (bus.rd_valid_o) begin
        exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL starve_rd_data c=%0d: got %0h want %0h", c, bus.rd_data_o, exp_d); end
      end
      if (exp_rd) sb.push_back(pat(bus.rd_addr_i));
      prev_rd = exp_rd;
      step();
      if (c == 8) bus.wb_req_i = 1'b0;
    end
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    if (bus.rd_valid_o) begin
      exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
      total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL starve_rd_data_last: got %0h want %0h", bus.rd_data_o, exp_d); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL starve_sb_drain: got %0d want 0", sb.size()); end
    sb.delete();
    step();
  endtask

  task automatic test_lock();
    logic exp_rd, exp_wb, exp_host, prev_rd;
    clear_reqs();
    step();
    bus.rd_addr_i = 12'h060; bus.rd_req_i = 1'b1; bus.rd_lock_i = 1'b1;
    bus.wb_addr_i = 12'h0A1; bus.wb_data_i = D_WB; bus.wb_req_i = 1'b1;
    bus.host_addr_i = 12'h0B0; bus.host_data_i = D_HOST; bus.host_req_i = 1'b1;
    prev_rd = 1'b0;
    for (int c = 0; c < 23; c++) begin
      exp_wb   = (c == 20);
      exp_host = (c == 21);
      exp_rd   = !(exp_wb || exp_host);
      @(negedge clk);
      total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== {exp_rd, exp_wb, exp_host}) begin bad++; $display("FAIL lock_gnts c=%0d: got %0b want %0b", c, {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}, {exp_rd, exp_wb, exp_host}); end
      total++; if (bus.rd_valid_o !== prev_rd) begin bad++; $display("FAIL lock_rd_valid c=%0d: got %0h want %0h", c, bus.rd_valid_o, prev_rd); end
      if (exp_wb) begin
        total++; if (bus.ub_addr_o !== 12'h0A1) begin bad++; $display("FAIL lock_wb_addr: got %0h want 0a1", bus.ub_addr_o); end
      end
      if (exp_host) begin
        total++; if (bus.ub_wdata_o !== D_HOST) begin bad++; $display("FAIL lock_host_wdata: got %0h want %0h", bus.ub_wdata_o, D_HOST); end
      end
      if (bus.rd_valid_o) begin
        exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL lock_rd_data c=%0d: got %0h want %0h", c, bus.rd_data_o, exp_d); end
      end
      if (exp_rd) sb.push_back(pat(bus.rd_addr_i));
      prev_rd = exp_rd;
      step();
      if (exp_rd)  bus.rd_addr_i = bus.rd_addr_i + 12'd1;
      if (c == 19) bus.rd_lock_i = 1'b0;
      if (c == 20) bus.wb_req_i = 1'b0;
      if (c == 21) bus.host_req_i = 1'b0;
      if (c == 22) bus.rd_req_i = 1'b0;
    end
    @(negedge clk);
    if (bus.rd_valid_o) begin
      exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
      total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL lock_rd_data_last: got %0h want %0h", bus.rd_data_o, exp_d); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL lock_sb_drain: got %0d want 0", sb.size()); end
    sb.delete();
    step();
  endtask

  task automatic test_both_starved();
    logic exp_rd, exp_wb, exp_host;
    clear_reqs();
    step();
    bus.rd_addr_i = 12'h0D0; bus.rd_req_i = 1'b1;
    bus.wb_addr_i = 12'h0A2; bus.wb_data_i = D_WB; bus.wb_req_i = 1'b1;
    bus.host_addr_i = 12'h0B2; bus.host_data_i = D_HOST; bus.host_req_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_wb   = (c == 8);
      exp_host = (c == 9);
      exp_rd   = !(exp_wb || exp_host);
      @(negedge clk);
      total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== {exp_rd, exp_wb, exp_host}) begin bad++; $display("FAIL both_gnts c=%0d: got %0b want %0b", c, {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}, {exp_rd, exp_wb, exp_host}); end
      if (c == 8) begin
        total++; if (dut.u_host_cnt.starved_o !== 1'b1) begin bad++; $display("FAIL both_host_starved: got %0h want 1", dut.u_host_cnt.starved_o); end
      end
      if (c == 9) begin
        total++; if (dut.u_wb_cnt.count_q !== '0) begin bad++; $display("FAIL both_wb_cnt_clr: got %0h want 0", dut.u_wb_cnt.count_q); end
      end
      if (c == 10) begin
        total++; if (dut.u_host_cnt.count_q !== '0) begin bad++; $display("FAIL both_host_cnt_clr: got %0h want 0", dut.u_host_cnt.count_q); end
      end
      if (bus.rd_valid_o) begin
        exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL both_rd_data c=%0d: got %0h want %0h", c, bus.rd_data_o, exp_d); end
      end
      if (exp_rd) sb.push_back(pat(bus.rd_addr_i));
      step();
    end
    clear_reqs();
    @(negedge clk);
    if (bus.rd_valid_o) begin
      exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
      total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL both_rd_data_last: got %0h want %0h", bus.rd_data_o, exp_d); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL both_sb_drain: got %0d want 0", sb.size()); end
    sb.delete();
    step();
  endtask

  task automatic test_reset_lock();
    clear_reqs();
    step();
    bus.rd_addr_i = 12'h0C0; bus.rd_req_i = 1'b1; bus.rd_lock_i = 1'b1;
    bus.wb_addr_i = 12'h0A3; bus.wb_data_i = D_WB; bus.wb_req_i = 1'b1;
    @(negedge clk);
    total++; if (bus.rd_gnt_o !== 1'b1) begin bad++; $display("FAIL rl_gnt0: got %0h want 1", bus.rd_gnt_o); end
    sb.push_back(pat(12'h0C0));
    step();
    @(negedge clk);
    total++; if (dut.state_q !== ST_LOCK) begin bad++; $display("FAIL rl_state_lock: got %0h want %0h", dut.state_q, ST_LOCK); end
    total++; if (bus.rd_gnt_o !== 1'b1) begin bad++; $display("FAIL rl_gnt1: got %0h want 1", bus.rd_gnt_o); end
    if (bus.rd_valid_o) begin
      exp_d = (sb.size() != 0) ? sb.pop_front() : 'x;
      total++; if (bus.rd_data_o !== exp_d) begin bad++; $display("FAIL rl_rd_data: got %0h want %0h", bus.rd_data_o, exp_d); end
    end
    #1 rst = 1'b1;
    sb.delete();
    #1;
    total++; if ({bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o} !== 3'b000) begin bad++; $display("FAIL rl_gnts_drop: got %0b want 000", {bus.rd_gnt_o, bus.wb_gnt_o, bus.host_gnt_o}); end
    total++; if (bus.ub_en_o !== 1'b0 || bus.ub_we_o !== 1'b0) begin bad++; $display("FAIL rl_en_drop: got en=%0h we=%0h want 0 0", bus.ub_en_o, bus.ub_we_o); end
    @(negedge clk);
    total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL rl_valid_next: got %0h want 0", bus.rd_valid_o); end
    total++; if (bus.rd_gnt_o !== 1'b0) begin bad++; $display("FAIL rl_gnt_in_rst: got %0h want 0", bus.rd_gnt_o); end
    #1 rst = 1'b0;
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    total++; if (dut.state_q !== ST_ARB) begin bad++; $display("FAIL rl_state_arb: got %0h want %0h", dut.state_q, ST_ARB); end
    total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL rl_valid_after: got %0h want 0", bus.rd_valid_o); end
    total++; if (bus.wb_gnt_o !== 1'b1 || bus.ub_addr_o !== 12'h0A3) begin bad++; $display("FAIL rl_wb_after: got gnt=%0h addr=%0h want 1 0a3", bus.wb_gnt_o, bus.ub_addr_o); end
    step();
    clear_reqs();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_reqs();
    test_reset();
    test_priority();
    test_starve();
    test_lock();
    test_both_starved();
    test_reset_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_buffer_arbiter.md
UNIFIED_BUFFER_ARBITER -- requirements
Module: unified_buffer_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: wait cycles after which a write requester is promoted above the read requester.
REQ-002 Parameter UB_DATA_W, default 256: unified buffer word width.
REQ-003 Parameter UB_ADDR_W, default 12: unified buffer address width.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 rd_req_i  in  1  array activation-fetch read request.
REQ-007 rd_addr_i  in  UB_ADDR_W  read address.
REQ-008 rd_lock_i  in  1  read requester asks to keep the port for a tile burst.
REQ-009 rd_gnt_o  out  1  read granted this cycle.
REQ-010 rd_data_o  out  UB_DATA_W  read data, equal to ub_rdata_i.
REQ-011 rd_valid_o  out  1  rd_data_o valid for the read granted in the previous cycle.
REQ-012 wb_req_i / wb_addr_i / wb_data_i  in  1 / UB_ADDR_W / UB_DATA_W  accumulator writeback write request.
REQ-013 wb_gnt_o  out  1  writeback granted this cycle.
REQ-014 host_req_i / host_addr_i / host_data_i  in  1 / UB_ADDR_W / UB_DATA_W  host load write request.
REQ-015 host_gnt_o  out  1  host granted this cycle.
REQ-016 ub_en_o, ub_we_o  out  1, 1  buffer port enable and write enable.
REQ-017 ub_addr_o, ub_wdata_o  out  UB_ADDR_W, UB_DATA_W  buffer port address and write data.
REQ-018 ub_rdata_i  in  UB_DATA_W  buffer read data; synchronous read, 1-cycle latency.

Function
REQ-019 The block SHALL assert at most one grant per cycle; grants are combinational from current requests and registered state.
REQ-020 A requester SHALL hold req, addr and data stable until its grant; one grant transfers exactly one word.
REQ-021 ub_en_o SHALL equal the OR of the grants; ub_we_o = wb_gnt_o | host_gnt_o; ub_addr_o and ub_wdata_o SHALL be muxed from the granted requester (ub_wdata_o = 0 on read).
REQ-022 rd_valid_o SHALL be rd_gnt_o delayed one cycle.
REQ-023 FSM states ARB and LOCK; in ARB, normal priority SHALL be rd > wb > host.
REQ-024 Each write requester SHALL have a wait counter: +1 per cycle with req high and no grant, saturating at STARVE_LIMIT, cleared on its grant or when its req is low.
REQ-025 In ARB, a requester whose counter equals STARVE_LIMIT SHALL win over rd; if both are starved, wb wins over host.
REQ-026 ARB->LOCK on a cycle where rd is granted and rd_lock_i=1; LOCK->ARB when rd_lock_i=0 or rd_req_i=0, evaluated each cycle.
REQ-027 In LOCK only rd SHALL be granted (whenever rd_req_i=1); write counters keep counting and saturating.
REQ-028 On the LOCK->ARB cycle, arbitration SHALL apply ARB rules in that same cycle.
REQ-029 With no requests: all grants 0, ub_en_o=0, FSM in ARB.

Reset
REQ-030 While rst_i=1: FSM=ARB, both counters=0, rd_valid_o=0; all grants and ub_en_o/ub_we_o SHALL be 0 regardless of requests.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; an in-flight read's rd_valid_o SHALL NOT appear after reset.

Structure
REQ-032 tpu_package SHALL hold UB_ADDR_W, UB_DATA_W, the FSM state enum and requester enum {REQ_RD, REQ_WB, REQ_HOST}.
REQ-033 The saturating wait counter SHALL be one sub-module, ub_starve_counter, instantiated twice.

Verification
REQ-034 rd, wb, host all requesting at addresses 0x010/0x020/0x030 -> rd_gnt_o cycle 0, ub_addr_o=0x010, ub_we_o=0, rd_valid_o cycle 1 with ub_rdata_i passed through.
REQ-035 rd_req_i held high continuously, wb_req_i high -> wb_gnt_o exactly 8 cycles after wb request starts (STARVE_LIMIT=8), then rd resumes.
REQ-036 rd_lock_i=1 for 20 granted reads, wb and host pending -> only rd granted for 20 cycles; on lock release wb granted first, then host.
REQ-037 wb and host both starved same cycle -> wb_gnt_o first, host_gnt_o next cycle, counters cleared on each grant.
REQ-038 rst_i pulsed during LOCK with rd granted -> grants and ub_en_o drop immediately, rd_valid_o=0 next cycle, FSM=ARB after release.
